// File: rtl/si_bus_arbiter.sv
// si_bus_arbiter: round-robin arbiter sharing one simprisc si port between NUM_REQ driver blocks.
// Define SI_ARB_TIMEOUT_EN to abort a transaction whose m_fin does not arrive within TIMEOUT cycles.
module si_bus_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int AW      = 9,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic [NUM_REQ-1:0]    req_exec,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_fin,
    output logic [DW-1:0]         req_rdata,
    output logic                  req_err,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  m_exec,
    output logic                  m_we,
    output logic [AW-1:0]         m_address,
    output logic [DW-1:0]         m_data,
    input  logic                  m_fin,
    input  logic [DW-1:0]         m_rdata
);

    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_nx;
    logic [IW-1:0]      last_grant, last_grant_nx;
    logic [IW-1:0]      grant_idx, grant_idx_nx;
    logic [NUM_REQ-1:0] grant_nx, req_fin_nx;
    logic               m_exec_nx, m_we_nx, req_err_nx;
    logic [AW-1:0]      m_address_nx;
    logic [DW-1:0]      m_data_nx, req_rdata_nx;
    logic [IW-1:0]      pick_idx;
    logic               pick_valid;
    logic [IW:0]        rr_sum;

`ifdef SI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] busy_cnt, busy_cnt_nx;
`endif

    if ((NUM_REQ < 2) || (NUM_REQ > 8) || (TIMEOUT < 2)) begin : g_param_check
        $error("si_bus_arbiter: NUM_REQ must be 2..8 and TIMEOUT at least 2");
    end

    // Walk downward so the closest requester after last_grant is the one that sticks.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        rr_sum     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            rr_sum = {1'b0, last_grant} + (IW+1)'(k);
            if (rr_sum >= (IW+1)'(NUM_REQ)) begin
                rr_sum = rr_sum - (IW+1)'(NUM_REQ);
            end
            if (req_exec[rr_sum[IW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = rr_sum[IW-1:0];
            end
        end
    end

    always_comb begin
        state_nx      = state;
        last_grant_nx = last_grant;
        grant_idx_nx  = grant_idx;
        grant_nx      = grant;
        req_fin_nx    = req_fin;
        req_rdata_nx  = req_rdata;
        req_err_nx    = req_err;
        m_exec_nx     = m_exec;
        m_we_nx       = m_we;
        m_address_nx  = m_address;
        m_data_nx     = m_data;
`ifdef SI_ARB_TIMEOUT_EN
        busy_cnt_nx   = busy_cnt;
`endif
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant_idx_nx = pick_idx;
                    grant_nx     = NUM_REQ'(1) << pick_idx;
                    m_exec_nx    = 1'b1;
                    m_we_nx      = req_we[pick_idx];
                    m_address_nx = req_addr[pick_idx*AW +: AW];
                    m_data_nx    = req_data[pick_idx*DW +: DW];
                    state_nx     = BUSY;
`ifdef SI_ARB_TIMEOUT_EN
                    busy_cnt_nx  = '0;
`endif
                end
            end
            BUSY: begin
                if (m_fin) begin
                    m_exec_nx     = 1'b0;
                    req_fin_nx    = grant;
                    req_rdata_nx  = m_rdata;
                    req_err_nx    = 1'b0;
                    last_grant_nx = grant_idx;
                    state_nx      = DONE;
                end
`ifdef SI_ARB_TIMEOUT_EN
                else if (busy_cnt == CW'(TIMEOUT - 1)) begin
                    m_exec_nx     = 1'b0;
                    req_fin_nx    = grant;
                    req_rdata_nx  = '0;
                    req_err_nx    = 1'b1;
                    last_grant_nx = grant_idx;
                    state_nx      = DONE;
                end else begin
                    busy_cnt_nx   = busy_cnt + 1'b1;
                end
`endif
            end
            DONE: begin
                req_fin_nx = '0;
                req_err_nx = 1'b0;
                grant_nx   = '0;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= IDLE;
            last_grant <= IW'(NUM_REQ - 1);
            grant_idx  <= '0;
            grant      <= '0;
            req_fin    <= '0;
            req_rdata  <= '0;
            req_err    <= 1'b0;
            m_exec     <= 1'b0;
            m_we       <= 1'b0;
            m_address  <= '0;
            m_data     <= '0;
`ifdef SI_ARB_TIMEOUT_EN
            busy_cnt   <= '0;
`endif
        end else begin
            state      <= state_nx;
            last_grant <= last_grant_nx;
            grant_idx  <= grant_idx_nx;
            grant      <= grant_nx;
            req_fin    <= req_fin_nx;
            req_rdata  <= req_rdata_nx;
            req_err    <= req_err_nx;
            m_exec     <= m_exec_nx;
            m_we       <= m_we_nx;
            m_address  <= m_address_nx;
            m_data     <= m_data_nx;
`ifdef SI_ARB_TIMEOUT_EN
            busy_cnt   <= busy_cnt_nx;
`endif
        end
    end

endmodule

// File: tb/tb_si_bus_arbiter.sv
// tb_si_bus_arbiter: directed stimulus for si_bus_arbiter, checked against a transaction-level model
// every cycle plus hand-computed expectations for each scenario.
module tb_si_bus_arbiter;

    localparam int NUM_REQ = 2;
    localparam int AW      = 9;
    localparam int DW      = 32;
    localparam int TIMEOUT = 8;

    logic                  clk;
    logic                  nreset;
    logic [NUM_REQ-1:0]    req_exec;
    logic [NUM_REQ-1:0]    req_we;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]    req_fin;
    logic [DW-1:0]         req_rdata;
    logic                  req_err;
    logic [NUM_REQ-1:0]    grant;
    logic                  m_exec;
    logic                  m_we;
    logic [AW-1:0]         m_address;
    logic [DW-1:0]         m_data;
    logic                  m_fin;
    logic [DW-1:0]         m_rdata;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    si_bus_arbiter #(
        .NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .nreset(nreset),
        .req_exec(req_exec), .req_we(req_we), .req_addr(req_addr), .req_data(req_data),
        .req_fin(req_fin), .req_rdata(req_rdata), .req_err(req_err), .grant(grant),
        .m_exec(m_exec), .m_we(m_we), .m_address(m_address), .m_data(m_data),
        .m_fin(m_fin), .m_rdata(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Transaction-level model: phase 0 waiting, 1 owned by a requester, 2 completion pulse.
    int m_phase, m_owner, m_last, m_busy, m_pick;
    logic [NUM_REQ-1:0] e_grant, e_fin;
    logic               e_mexec, e_we, e_err;
    logic [AW-1:0]      e_addr;
    logic [DW-1:0]      e_data, e_rdata;

    function automatic int rr_pick(int last, logic [NUM_REQ-1:0] ex);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (ex[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    always_comb m_pick = rr_pick(m_last, req_exec);

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            m_phase <= 0; m_owner <= 0; m_last <= NUM_REQ - 1; m_busy <= 0;
            e_grant <= '0; e_fin <= '0; e_mexec <= 1'b0; e_we <= 1'b0; e_err <= 1'b0;
            e_addr <= '0; e_data <= '0; e_rdata <= '0;
        end else begin
            case (m_phase)
                0: if (m_pick >= 0) begin
                    m_owner <= m_pick;
                    e_grant <= NUM_REQ'(1) << m_pick;
                    e_mexec <= 1'b1;
                    e_we    <= req_we[m_pick];
                    e_addr  <= req_addr[m_pick*AW +: AW];
                    e_data  <= req_data[m_pick*DW +: DW];
                    m_busy  <= 0;
                    m_phase <= 1;
                end
                1: if (m_fin) begin
                    e_mexec <= 1'b0;
                    e_fin   <= NUM_REQ'(1) << m_owner;
                    e_rdata <= m_rdata;
                    e_err   <= 1'b0;
                    m_last  <= m_owner;
                    m_phase <= 2;
                end
`ifdef SI_ARB_TIMEOUT_EN
                else if (m_busy + 1 == TIMEOUT) begin
                    e_mexec <= 1'b0;
                    e_fin   <= NUM_REQ'(1) << m_owner;
                    e_rdata <= '0;
                    e_err   <= 1'b1;
                    m_last  <= m_owner;
                    m_phase <= 2;
                end else begin
                    m_busy  <= m_busy + 1;
                end
`endif
                default: begin
                    e_fin   <= '0;
                    e_err   <= 1'b0;
                    e_grant <= '0;
                    m_phase <= 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check_output("grant", 64'(grant), 64'(e_grant));
            check_output("req_fin", 64'(req_fin), 64'(e_fin));
            check_output("req_err", 64'(req_err), 64'(e_err));
            check_output("m_exec", 64'(m_exec), 64'(e_mexec));
            check_output("m_we", 64'(m_we), 64'(e_we));
            check_output("m_address", 64'(m_address), 64'(e_addr));
            check_output("m_data", 64'(m_data), 64'(e_data));
            if (e_fin != '0) check_output("req_rdata", 64'(req_rdata), 64'(e_rdata));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int i, input bit ex, input bit we,
                                  input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_exec[i]          = ex;
        req_we[i]            = we;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [NUM_REQ-1:0] g_seq [4];
    int                 c_seq [4];
    int                 n_rise, cyc, lat;
    bit                 prev_exec;

    initial begin
        nreset = 1'b0; req_exec = '0; req_we = '0; req_addr = '0; req_data = '0;
        m_fin = 1'b0; m_rdata = '0;
        repeat (3) @(posedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        check_output("rst_mexec", 64'(m_exec), 64'd0);
        check_output("rst_grant", 64'(grant), 64'd0);
        check_output("rst_fin", 64'(req_fin), 64'd0);
        tick();
        nreset = 1'b1;
        tick();

        // Scenario 1: single write from requester 0, completion three cycles later.
        apply_stimulus(0, 1, 1, 9'h100, 32'hDEADBEEF);
        tick();
        @(negedge clk);
        check_output("t1_mexec", 64'(m_exec), 64'd1);
        check_output("t1_addr", 64'(m_address), 64'h100);
        check_output("t1_data", 64'(m_data), 64'hDEADBEEF);
        check_output("t1_grant", 64'(grant), 64'b01);
        tick();
        tick();
        m_fin = 1'b1;
        tick();
        m_fin = 1'b0;
        apply_stimulus(0, 0, 1, 9'h100, 32'hDEADBEEF);
        @(negedge clk);
        check_output("t1_fin", 64'(req_fin), 64'b01);
        tick();
        @(negedge clk);
        check_output("t1_fin_clr", 64'(req_fin), 64'd0);
        check_output("t1_grant_clr", 64'(grant), 64'd0);

        // Scenario 2: both requesters continuously, downstream completes at once.
        tick();
        m_fin = 1'b1;
        apply_stimulus(0, 1, 1, 9'h010, 32'h00000A0A);
        apply_stimulus(1, 1, 1, 9'h011, 32'h00000B0B);
        n_rise = 0; cyc = 0; prev_exec = m_exec;
        while (n_rise < 4 && cyc < 40) begin
            @(negedge clk);
            if (m_exec && !prev_exec) begin
                g_seq[n_rise] = grant;
                c_seq[n_rise] = cyc;
                n_rise++;
            end
            prev_exec = m_exec;
            cyc++;
        end
        check_output("t2_rises", 64'(n_rise), 64'd4);
        check_output("t2_g0", 64'(g_seq[0]), 64'b10);
        check_output("t2_g1", 64'(g_seq[1]), 64'b01);
        check_output("t2_g2", 64'(g_seq[2]), 64'b10);
        check_output("t2_g3", 64'(g_seq[3]), 64'b01);
        for (int i = 1; i < 4; i++) check_output("t2_spacing", 64'(c_seq[i] - c_seq[i-1]), 64'd3);
        tick();
        m_fin = 1'b0;
        req_exec = '0;
        tick();

        // Scenario 3: read by requester 1 returns downstream data with req_fin.
        apply_stimulus(1, 1, 0, 9'h004, 32'h0);
        tick();
        m_rdata = 32'h12345678;
        m_fin   = 1'b1;
        tick();
        m_fin   = 1'b0;
        m_rdata = 32'h0;
        apply_stimulus(1, 0, 0, 9'h004, 32'h0);
        @(negedge clk);
        check_output("t3_fin", 64'(req_fin), 64'b10);
        check_output("t3_rdata", 64'(req_rdata), 64'h12345678);
        check_output("t3_we", 64'(m_we), 64'd0);
        tick();

        // Scenario 4: requester 1 arrives while requester 0 is being served.
        apply_stimulus(0, 1, 1, 9'h020, 32'h11112222);
        tick();
        apply_stimulus(1, 1, 1, 9'h021, 32'h33334444);
        repeat (3) tick();
        @(negedge clk);
        check_output("t4_hold_grant", 64'(grant), 64'b01);
        check_output("t4_hold_addr", 64'(m_address), 64'h020);
        check_output("t4_hold_fin", 64'(req_fin), 64'd0);
        m_fin = 1'b1;
        tick();
        m_fin = 1'b0;
        req_exec[0] = 1'b0;
        @(negedge clk);
        check_output("t4_fin0", 64'(req_fin), 64'b01);
        tick();
        tick();
        @(negedge clk);
        check_output("t4_grant1", 64'(grant), 64'b10);
        check_output("t4_addr1", 64'(m_address), 64'h021);
        m_fin = 1'b1;
        tick();
        m_fin = 1'b0;
        req_exec[1] = 1'b0;
        tick();

        // Scenario 5: serve 0, then reset while 1 is in flight; 0 must win afterwards.
        apply_stimulus(0, 1, 1, 9'h030, 32'h55556666);
        tick();
        m_fin = 1'b1;
        tick();
        m_fin = 1'b0;
        req_exec[0] = 1'b0;
        tick();
        apply_stimulus(1, 1, 1, 9'h031, 32'h77778888);
        tick();
        tick();
        #2 nreset = 1'b0;
        #1;
        check_output("t5_rst_mexec", 64'(m_exec), 64'd0);
        check_output("t5_rst_grant", 64'(grant), 64'd0);
        check_output("t5_rst_fin", 64'(req_fin), 64'd0);
        req_exec = '0;
        tick();
        nreset = 1'b1;
        apply_stimulus(0, 1, 1, 9'h040, 32'h0000C0C0);
        apply_stimulus(1, 1, 1, 9'h041, 32'h0000D0D0);
        tick();
        @(negedge clk);
        check_output("t5_first", 64'(grant), 64'b01);
        m_fin = 1'b1;
        tick();
        m_fin = 1'b0;
        req_exec[0] = 1'b0;
        tick();
        tick();
        m_fin = 1'b1;
        tick();
        m_fin = 1'b0;
        req_exec[1] = 1'b0;
        tick();

        // Scenario 6: downstream never answers.
        apply_stimulus(0, 1, 1, 9'h050, 32'h0000E0E0);
        tick();
`ifdef SI_ARB_TIMEOUT_EN
        lat = 0;
        while (lat < 30) begin
            tick();
            lat++;
            if (req_fin != '0) break;
        end
        check_output("t6_latency", 64'(lat), 64'd8);
        check_output("t6_err", 64'(req_err), 64'd1);
        check_output("t6_mexec", 64'(m_exec), 64'd0);
        check_output("t6_rdata", 64'(req_rdata), 64'd0);
        req_exec[0] = 1'b0;
        tick();
`else
        lat = 0;
        repeat (20) tick();
        @(negedge clk);
        check_output("t6_mexec_held", 64'(m_exec), 64'd1);
        check_output("t6_err", 64'(req_err), 64'd0);
        check_output("t6_no_fin", 64'(req_fin), 64'd0);
        m_fin = 1'b1;
        tick();
        m_fin = 1'b0;
        req_exec[0] = 1'b0;
        tick();
`endif
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
